// File: rtl/muldiv_pool_with_lock.sv
// Lock-arbitrated shared multiply/divide engine: oldest issue ID wins the engine,
// which runs 32 shift-add / restoring shift-subtract iterations and then delivers a result.
module muldiv_pool_with_lock #(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]  req_id,
  input  logic [NUM_PORTS-1:0][1:0]           req_op,
  input  logic [NUM_PORTS-1:0][31:0]          req_a,
  input  logic [NUM_PORTS-1:0][31:0]          req_b,
  output logic [NUM_PORTS-1:0]                grant,
  output logic [NUM_PORTS-1:0]                done,
  output logic [31:0]                         res_hi,
  output logic [31:0]                         res_lo,
  output logic                                busy
);

  localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [OW-1:0]   r_owner, w_win;
  logic            w_any;
  logic [1:0]      r_op;
  logic [5:0]      r_cnt;
  logic [63:0]     r_acc;
  logic [31:0]     r_opnd;
  logic            r_neg_lo, r_neg_hi;

  logic [1:0]      w_sel_op;
  logic [31:0]     w_sel_a, w_sel_b, w_mag_a, w_mag_b;
  logic            w_a_neg, w_b_neg;
  logic [32:0]     w_sum;
  logic [33:0]     w_trial;
  logic [63:0]     w_mul_step, w_div_step, w_step, w_fix;
  logic            w_deliver;

  // Later ports replace the current best only when strictly older, so ties keep the lower index.
  always_comb begin
    logic [OW-1:0]       best;
    logic                found;
    logic [ID_WIDTH-1:0] diff;
    best  = '0;
    found = 1'b0;
    diff  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      diff = req_id[p] - req_id[best];
      if (req_valid[p] && (!found || diff[ID_WIDTH-1])) begin
        best  = OW'(p);
        found = 1'b1;
      end
    end
    w_win = best;
    w_any = found;
  end

  assign w_sel_op = req_op[w_win];
  assign w_sel_a  = req_a[w_win];
  assign w_sel_b  = req_b[w_win];
  assign w_a_neg  = ~w_sel_op[0] & w_sel_a[31];
  assign w_b_neg  = ~w_sel_op[0] & w_sel_b[31];
  assign w_mag_a  = w_a_neg ? -w_sel_a : w_sel_a;
  assign w_mag_b  = w_b_neg ? -w_sel_b : w_sel_b;

  // r_acc holds {hi, lo}: product/partial-product for MUL, remainder/quotient for DIV.
  assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_step = {w_sum, r_acc[31:1]};
  assign w_trial    = {1'b0, r_acc[63:31]} - {2'b00, r_opnd};
  assign w_div_step = w_trial[33] ? {r_acc[62:0], 1'b0}
                                  : {w_trial[31:0], r_acc[30:0], 1'b1};
  assign w_step     = r_op[1] ? w_div_step : w_mul_step;

  always_comb begin
    w_fix = w_step;
    if (!r_op[1]) begin
      if (r_neg_lo) w_fix = -w_step;
    end else begin
      w_fix = {(r_neg_hi ? -w_step[63:32] : w_step[63:32]),
               (r_neg_lo ? -w_step[31:0]  : w_step[31:0])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (!req_valid[r_owner]) w_next = S_IDLE;
               else if (r_cnt == 6'd31) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    done      = '0;
    w_deliver = (r_state == S_DONE) && req_valid[r_owner];
    if (r_state != S_IDLE) grant[r_owner] = 1'b1;
    if (w_deliver)         done[r_owner]  = 1'b1;
    res_hi = w_deliver ? r_acc[63:32] : '0;
    res_lo = w_deliver ? r_acc[31:0]  : '0;
    busy   = (r_state != S_IDLE);
  end

  // Divide-by-zero leaves the quotient unnegated so it reads all-ones and hi returns the dividend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner  <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_owner  <= w_win;
          r_op     <= w_sel_op;
          r_cnt    <= '0;
          r_opnd   <= w_sel_op[1] ? w_mag_b : w_mag_a;
          r_acc    <= {32'd0, (w_sel_op[1] ? w_mag_a : w_mag_b)};
          r_neg_hi <= w_a_neg;
          r_neg_lo <= w_sel_op[1] ? ((w_a_neg ^ w_b_neg) & (|w_sel_b)) : (w_a_neg ^ w_b_neg);
        end
        S_BUSY: begin
          r_acc <= (r_cnt == 6'd31) ? w_fix : w_step;
          r_cnt <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
